// File: rtl/cam_pkg.sv
// Shared types for the CAM write-side controller: FSM states, response status and op codes.
// Pure declarations, no logic.
package cam_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_SEARCH = 3'd2,
    S_CHECK  = 3'd3,
    S_WRITE  = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_DUP     = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_INVALID = 2'd3;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_DELETE = 1'b1;

endpackage

// File: rtl/encoder.sv
// Combinational priority encoder: index of the highest-priority set bit plus an any-set flag.
// Zero latency; no flow control.
module encoder #(
  parameter int    WIDTH        = 4,
  parameter string LSB_PRIORITY = "HIGH",
  localparam int   IW           = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic [IW-1:0]    o_index,
  output logic             o_valid
);

  always_comb begin
    o_index = '0;
    o_valid = |i_bits;
    // Later assignments win, so scan toward the favoured end last.
    if (LSB_PRIORITY == "HIGH") begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i_bits[i]) o_index = IW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i_bits[i]) o_index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cam_writer.sv
// CAM write controller: fills the CAM after reset, then serialises insert (dup-search, lowest-free alloc) and delete.
// Insert OK 4 / DUP,FULL 3 / INVALID 1 cycles; delete OK 2 / INVALID 1; one request in flight, req_ready only in IDLE.
module cam_writer
  import cam_pkg::*;
#(
  parameter int                    DATA_WIDTH = 4,
  parameter int                    ADDR_WIDTH = 2,
  parameter logic [DATA_WIDTH-1:0] FILL       = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  output logic [1:0]            resp_status,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  cam_start,
  output logic                  cam_write_enable,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_din,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

  localparam int                    ENTRIES  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0]   OCC_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_addr;
  logic [ENTRIES-1:0]    r_valid;
  logic [ADDR_WIDTH:0]   r_occ;
  logic                  r_op;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_hit;
  logic [ADDR_WIDTH-1:0] r_slot;
  logic [1:0]            r_resp_status;
  logic [ADDR_WIDTH-1:0] r_resp_addr;

  logic [ENTRIES-1:0]    w_free;
  logic [ADDR_WIDTH-1:0] w_free_idx;
  logic                  w_not_full;
  logic                  w_dup;

  assign w_free = ~r_valid;

  encoder #(
    .WIDTH       (ENTRIES),
    .LSB_PRIORITY("HIGH")
  ) u_free_enc (
    .i_bits (w_free),
    .o_index(w_free_idx),
    .o_valid(w_not_full)
  );

  // A stale hit on a cleared slot is not a duplicate.
  assign w_dup = r_hit && r_valid[cam_match_addr];

  assign occupancy   = r_occ;
  assign resp_status = r_resp_status;
  assign resp_addr   = r_resp_addr;

  always_comb begin
    w_state_nxt      = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    cam_start        = 1'b0;
    cam_write_enable = 1'b0;
    cam_write_addr   = '0;
    cam_din          = FILL;
    case (r_state)
      S_INIT: begin
        cam_write_enable = 1'b1;
        cam_write_addr   = r_init_addr;
        if (r_init_addr == ADDR_MAX) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_op == OP_INSERT) begin
            w_state_nxt = (req_data == FILL) ? S_RESP : S_SEARCH;
          end else begin
            w_state_nxt = r_valid[req_addr] ? S_WRITE : S_RESP;
          end
        end
      end
      S_SEARCH: begin
        cam_start   = 1'b1;
        cam_din     = r_data;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_state_nxt = (w_dup || !w_not_full) ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        cam_write_enable = 1'b1;
        if (r_op == OP_INSERT) begin
          cam_write_addr = r_slot;
          cam_din        = r_data;
        end else begin
          cam_write_addr = r_addr;
        end
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_INIT;
      r_init_addr   <= '0;
      r_valid       <= '0;
      r_occ         <= '0;
      r_op          <= OP_INSERT;
      r_data        <= '0;
      r_addr        <= '0;
      r_hit         <= 1'b0;
      r_slot        <= '0;
      r_resp_status <= ST_OK;
      r_resp_addr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_INIT: r_init_addr <= r_init_addr + 1'b1;
        S_IDLE: begin
          if (req_valid) begin
            r_op   <= req_op;
            r_data <= req_data;
            r_addr <= req_addr;
            if (req_op == OP_INSERT && req_data == FILL) begin
              r_resp_status <= ST_INVALID;
              r_resp_addr   <= '0;
            end else if (req_op == OP_DELETE && !r_valid[req_addr]) begin
              r_resp_status <= ST_INVALID;
              r_resp_addr   <= req_addr;
            end
          end
        end
        S_SEARCH: r_hit <= cam_match;
        S_CHECK: begin
          if (w_dup) begin
            r_resp_status <= ST_DUP;
            r_resp_addr   <= cam_match_addr;
          end else if (!w_not_full) begin
            r_resp_status <= ST_FULL;
            r_resp_addr   <= '0;
          end else begin
            r_slot <= w_free_idx;
          end
        end
        S_WRITE: begin
          r_resp_status <= ST_OK;
          if (r_op == OP_INSERT) begin
            r_valid[r_slot] <= 1'b1;
            r_resp_addr     <= r_slot;
            if (r_occ != OCC_MAX) r_occ <= r_occ + 1'b1;
          end else begin
            r_valid[r_addr] <= 1'b0;
            r_resp_addr     <= r_addr;
            if (r_occ != '0) r_occ <= r_occ - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
